// File: rtl/vxe_elastic_pipe.sv
// vxe_elastic_pipe: valid/ready register pipeline with per-stage valid bits.
// Stage NSTAGES-1 faces the producer; stage 0 drives the consumer. Empty
// stages always accept, so bubbles collapse behind a stalled head. A
// synchronous flush clears every valid bit, and count tracks occupancy.
module vxe_elastic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NSTAGES    = 2,
  parameter int CNT_WIDTH  = $clog2(NSTAGES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [NSTAGES-1:0]    v_reg;
  logic [NSTAGES-1:0]    v_next;
  logic [NSTAGES-1:0]    acc;
  logic [DATA_WIDTH-1:0] data_reg  [NSTAGES];
  logic [DATA_WIDTH-1:0] data_next [NSTAGES];
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  in_xfer;
  logic                  out_xfer;

  // A stage accepts when it, or any stage nearer the output, is empty, or
  // when the consumer takes the head. Written in closed form rather than as
  // a ripple so each bit depends only on registers and out_rdy.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_acc
      assign acc[gi] = out_rdy | ~(&v_reg[gi:0]);
    end
  endgenerate

  assign in_rdy   = acc[NSTAGES-1] & ~flush & nrst;
  assign out_vld  = v_reg[0] & ~flush;
  assign out_data = data_reg[0];
  assign count    = count_reg;
  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = out_vld & out_rdy;

  // Per-stage next state: an accepting stage takes whatever sits just
  // upstream (or the producer word for the input stage); a stalled stage
  // holds. Data only loads when a valid word arrives, so empty stages keep
  // stable contents.
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      logic                  src_v;
      logic [DATA_WIDTH-1:0] src_data;
      if (gi == NSTAGES - 1) begin : g_src_in
        assign src_v    = in_xfer;
        assign src_data = in_data;
      end else begin : g_src_up
        assign src_v    = v_reg[gi+1];
        assign src_data = data_reg[gi+1];
      end
      assign v_next[gi]    = ~flush & (acc[gi] ? src_v : v_reg[gi]);
      assign data_next[gi] = (~flush & acc[gi] & src_v) ? src_data : data_reg[gi];
    end
  endgenerate

  // Occupancy follows the handshakes; flush empties the pipe outright.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_WIDTH'(in_xfer) - CNT_WIDTH'(out_xfer);
    end
  end

  // Stage and counter registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v_reg     <= '0;
      count_reg <= '0;
      for (int s = 0; s < NSTAGES; s++) begin
        data_reg[s] <= '0;
      end
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
      for (int s = 0; s < NSTAGES; s++) begin
        data_reg[s] <= data_next[s];
      end
    end
  end

endmodule

// File: tb/tb_vxe_elastic_pipe.sv
// Testbench for vxe_elastic_pipe: three instances (1, 3 and 4 stages) share
// one producer/consumer stimulus stream. A slot-level reference model per
// instance holds the words in flight with their stage positions; a monitor
// compares the handshake outputs, occupancy and emerging data every cycle.
module tb_vxe_elastic_pipe;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b0;
  logic          flush = 1'b0;

  logic          in_rdy_w   [3];
  logic          out_vld_w  [3];
  logic [DW-1:0] out_data_w [3];
  logic [2:0]    count_w    [3];

  int ns_tab [3] = '{1, 3, 4};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words in flight, oldest first, with their stage index.
  logic [DW-1:0] q_data [3][$];
  int            q_pos  [3][$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NS = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
      logic [$clog2(NS+1)-1:0] cnt;
      vxe_elastic_pipe #(.DATA_WIDTH(DW), .NSTAGES(NS)) u_dut (
        .clk     (clk),
        .nrst    (nrst),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy_w[gi]),
        .out_data(out_data_w[gi]),
        .out_vld (out_vld_w[gi]),
        .out_rdy (out_rdy),
        .flush   (flush),
        .count   (cnt)
      );
      assign count_w[gi] = 3'(cnt);
    end
  endgenerate

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [N=%0d] t=%0t: got %0h, expected %0h", name, ns_tab[i], $time, act, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model across
  // the coming clock edge using the inputs currently applied.
  task automatic eval_inst(input int i);
    int   n, sz, prev_new;
    logic e_rdy, e_vld, in_x;
    n  = ns_tab[i];
    sz = q_data[i].size();
    if (nrst !== 1'b1) begin
      chk("reset out_vld", i, 32'(out_vld_w[i]), 0);
      chk("reset in_rdy", i, 32'(in_rdy_w[i]), 0);
      chk("reset count", i, 32'(count_w[i]), 0);
      chk("reset out_data", i, 32'(out_data_w[i]), 0);
      q_data[i].delete();
      q_pos[i].delete();
      return;
    end
    e_rdy = !flush && (sz < n || out_rdy);
    e_vld = !flush && sz > 0 && q_pos[i][0] == 0;
    chk("in_rdy", i, 32'(in_rdy_w[i]), 32'(e_rdy));
    chk("out_vld", i, 32'(out_vld_w[i]), 32'(e_vld));
    chk("count", i, 32'(count_w[i]), 32'(sz));
    if (e_vld) chk("out_data", i, 32'(out_data_w[i]), 32'(q_data[i][0]));
    if (flush) begin
      $display("N=%0d flush drops %0d word(s)", n, sz);
      q_data[i].delete();
      q_pos[i].delete();
      return;
    end
    in_x = e_rdy && in_vld;
    if (e_vld && out_rdy) begin
      $display("N=%0d pop  %04h", n, q_data[i][0]);
      void'(q_data[i].pop_front());
      void'(q_pos[i].pop_front());
    end
    // Each word steps one slot toward the output unless the slot ahead is
    // still occupied after the word in front has moved.
    prev_new = -1;
    for (int j = 0; j < q_pos[i].size(); j++) begin
      if (q_pos[i][j] - 1 > prev_new) q_pos[i][j] = q_pos[i][j] - 1;
      prev_new = q_pos[i][j];
    end
    if (in_x) begin
      $display("N=%0d push %04h", n, in_data);
      q_data[i].push_back(in_data);
      q_pos[i].push_back(n - 1);
    end
  endtask

  // Monitor: per-cycle checks at the falling edge; a reset falling while the
  // clock is high gets its own check before the next rising edge.
  initial begin
    #7;
    forever begin
      @(negedge clk or negedge nrst);
      if (clk === 1'b1) begin
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("async reset out_vld", i, 32'(out_vld_w[i]), 0);
          chk("async reset in_rdy", i, 32'(in_rdy_w[i]), 0);
          chk("async reset count", i, 32'(count_w[i]), 0);
          chk("async reset out_data", i, 32'(out_data_w[i]), 0);
          q_data[i].delete();
          q_pos[i].delete();
        end
      end else begin
        for (int i = 0; i < 3; i++) eval_inst(i);
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic f);
    in_vld  = v;
    in_data = d;
    out_rdy = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input int hold);
    @(posedge clk);
    #3;
    nrst   = 1'b0;
    in_vld = 1'b0;
    flush  = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    repeat (2) drive(0, 16'h0, 0, 0);
    nrst = 1'b1;
    drive(0, 16'h0, 1, 0);

    // Back-to-back stream with the consumer always ready.
    for (int k = 1; k <= 8; k++) drive(1, 16'(k), 1, 0);
    repeat (5) drive(0, 16'h0, 1, 0);

    // Backpressure: fill, hold 0xD while full, then release.
    drive(1, 16'hA, 0, 0);
    drive(1, 16'hB, 0, 0);
    drive(1, 16'hC, 0, 0);
    repeat (4) drive(1, 16'hD, 0, 0);
    drive(1, 16'hD, 1, 0);
    repeat (6) drive(0, 16'h0, 1, 0);

    // Bubble collapse behind a stalled head.
    drive(1, 16'h11, 0, 0);
    repeat (2) drive(0, 16'h0, 0, 0);
    drive(1, 16'h22, 0, 0);
    repeat (2) drive(0, 16'h0, 0, 0);

    // Flush a partly filled pipe, then a lone word afterwards.
    drive(1, 16'h33, 0, 0);
    drive(0, 16'h0, 0, 0);
    drive(1, 16'h44, 1, 1);
    drive(0, 16'h0, 1, 0);
    drive(1, 16'h55, 1, 0);
    repeat (6) drive(0, 16'h0, 1, 0);

    // Asynchronous reset with words in flight, then a clean restart.
    drive(1, 16'h61, 0, 0);
    drive(1, 16'h62, 0, 0);
    drive(0, 16'h0, 0, 0);
    async_reset(2);
    for (int k = 0; k < 4; k++) drive(1, 16'(16'h71 + k), 1, 0);
    repeat (6) drive(0, 16'h0, 1, 0);

    // Consumer toggling ready every cycle.
    for (int k = 1; k <= 8; k++) begin
      drive(1, 16'(k), 1, 0);
      drive(1, 16'(k), 0, 0);
    end
    repeat (6) drive(0, 16'h0, 1, 0);

    // Randomized traffic with varying backpressure, rare flushes and resets.
    for (int k = 0; k < 600; k++) begin
      int bias;
      bias = (k / 100) % 3;
      if (k == 250 || k == 470) async_reset(1 + (k % 2));
      drive($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 3) >= bias, $urandom_range(0, 49) == 0);
    end
    repeat (8) drive(0, 16'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vxe_elastic_pipe.md
Name: vxe_elastic_pipe

Overview:
Parametrised elastic pipeline. It is the valid/ready successor to the enable-driven fixed shift pipe. Each stage carries its own valid bit, so the block supports per-stage stall, bubble collapsing, synchronous flush and an occupancy count. It sits between producer and consumer datapath units wherever a fixed-latency register pipe must tolerate downstream backpressure without losing or duplicating data.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
NSTAGES, 2, number of register stages (>=1); minimum unstalled latency
CNT_WIDTH, $clog2(NSTAGES+1), width of occupancy counter (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
in_data  input  DATA_WIDTH  payload from producer
in_vld  input  1  producer has valid payload
in_rdy  output  1  pipe accepts payload this cycle
out_data  output  DATA_WIDTH  payload to consumer (stage 0 register)
out_vld  output  1  stage 0 holds valid payload
out_rdy  input  1  consumer accepts payload this cycle
flush  input  1  synchronous flush: discard all payloads
count  output  CNT_WIDTH  number of valid stages (registered)

Behaviour:
- Interface (already decided): one clock `clk`. Reset `nrst` is asynchronous and active-low.
- Reset (nrst=0, asynchronous): all stage valids=0, all stage data=0, count=0. Outputs during reset: out_vld=0, out_data=0, in_rdy=0 (forced while nrst=0).
- Stage order: stage NSTAGES-1 is the input side; stage 0 is the output side. out_data=data[0]; out_vld=v[0] & ~flush.
- Accept chain (combinational, output side to input side):
  - acc[0] = ~v[0] | out_rdy
  - acc[s] = ~v[s] | acc[s-1] for s>=1
  - in_rdy = acc[NSTAGES-1] & ~flush & nrst
- Transfers:
  - Input transfer = in_vld & in_rdy.
  - Output transfer = out_vld & out_rdy.
  - Any transfer commits only at the rising clk edge.
- Stage update at posedge, no flush:
  - Stage s>=1 with acc[s-1]=1 moves data[s]/v[s] into stage s-1.
  - Stage NSTAGES-1 loads in_data with valid = (in_vld & in_rdy) when acc[NSTAGES-1]=1.
  - A stage whose acc is 0 holds data and valid unchanged.
  - Data registers load only when their stage accepts. Data in invalid stages is don't-care; it stays stable, never X after reset.
- Bubble collapse: an invalid stage always accepts, so a stalled head does not block upstream entries from advancing into empty slots. in_rdy stays 1 until all NSTAGES are valid and out_rdy=0.
- Latency and throughput:
  - Unstalled latency: a word accepted at edge k shows out_vld=1 after edge k+NSTAGES-1. With NSTAGES=1 it appears after edge k.
  - Throughput is 1 word/cycle when out_rdy=1, for any NSTAGES.
- Full: all v=1 and out_rdy=0 gives in_rdy=0. With all v=1 and out_rdy=1, in_rdy=1: simultaneous in/out transfer and the pipe shifts.
- Empty: all v=0 gives out_vld=0 and in_rdy=1 (if no flush).
- Flush (sync, highest priority):
  - Next edge: all v=0 and count=0. Data registers hold.
  - During the flush cycle, in_rdy=0 and out_vld=0, so no transfer occurs.
- count:
  - count_next = count + in_xfer - out_xfer; 0 on flush.
  - Invariant: count equals popcount(v) and never exceeds NSTAGES.
- Ordering: FIFO order preserved. No word is dropped or duplicated except by flush or reset.
- Reset mid-operation: in-flight words are lost immediately and outputs take their reset values asynchronously. Operation resumes on the first edge after nrst rises.
- in_data/in_vld are sampled only when in_rdy=1. A producer holding in_vld while in_rdy=0 is legal.

Test Plan:
- NSTAGES=3, out_rdy=1, stream 0x1..0x8 back-to-back: out_data=0x1 appears 2 cycles after its accept edge. One word/cycle, in order. count stays ≤3.
- NSTAGES=3, out_rdy=0, push 0xA,0xB,0xC,0xD: first three accepted (count=3), in_rdy=0, 0xD held. Raise out_rdy: 0xA,0xB,0xC,0xD emerge in order, no gaps.
- Bubble collapse, NSTAGES=4: push 0x11, idle 2 cycles, push 0x22 with out_rdy=0. The two words pack into stages 0,1 and count=2. in_rdy remains 1.
- Flush with count=3: next cycle count=0 and out_vld=0. in_rdy=0 during the flush cycle. A new push 0x55 afterwards emerges alone.
- Assert nrst=0 mid-stream (count=2): out_vld, in_rdy, count go 0 asynchronously before the next edge, and out_data=0. After release, the stream restarts cleanly.
- NSTAGES=1, out_rdy toggling 1,0,1,0: no loss or duplication. out_data follows accepted order 0x1,0x2,…
